time_stamp_tx: RTL and testbench
================================

Name: time_stamp_tx

Overview:
- Reads the time fields produced by the team's seconds/minutes/hours/day/month clock counter.
- Snapshots the fields on request and serialises them as a fixed-format ASCII line, "MM-DD HH:MM:SS" followed by an end of line.
- Sends the line one byte at a time over a valid/ready byte stream into the UART transmitter.
- Its job is to get time values out of the counter and onto the UART link.

Parameters:
- DELIM_DATE, 8'h2D, separator byte between month and day (default "-").
- DELIM_TIME, 8'h3A, separator byte between hour/min and min/sec (default ":").
- EOL_CRLF, 1, 1 = end line with CR (8'h0D) then LF (8'h0A), 16-byte frame; 0 = LF only, 15-byte frame.

Ports:
- clk_sys  in  1  system clock, all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to snapshot the fields and send one frame.
- sec  in  7  seconds field from the clock counter.
- min  in  7  minutes field.
- hour  in  6  hours field.
- day  in  6  day field.
- month  in  5  month field.
- tx_data  out  8  ASCII byte to the UART transmitter.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  UART transmitter accepts tx_data this cycle.
- busy  out  1  a frame is in progress.
- done  out  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset: synchronous, active-high. At the first rising edge with reset=1: tx_data=8'h00, tx_valid=0, busy=0, done=0, FSM=IDLE, byte index=0, snapshot registers=0.
- FSM states: IDLE, SEND, DONE.
- IDLE:
  - start=1 captures sec/min/hour/day/month into snapshot registers and clears the byte index.
  - Next state SEND; busy=1 and tx_valid=1 from the next cycle (1-cycle latency).
- SEND:
  - tx_data = frame byte [index].
  - A byte is transferred on a cycle where tx_valid=1 and tx_ready=1; the index then increments.
  - The transfer of the last byte moves the FSM to DONE.
  - While tx_valid=1 and tx_ready=0, tx_data and the index hold unchanged.
- DONE: one cycle with done=1, tx_valid=0, busy=0. Next state IDLE.
- Frame byte order:
  - month tens, month units, DELIM_DATE, day tens, day units, 8'h20 (space);
  - hour tens, hour units, DELIM_TIME, min tens, min units, DELIM_TIME, sec tens, sec units;
  - then CR LF, or LF alone when EOL_CRLF=0.
- Digit encoding:
  - Each field is converted from binary to two decimal digits, emitted as 8'h30 + digit.
  - Any snapshot value > 99 (possible on the 7-bit fields) saturates to "99".
  - No range check otherwise: month=31 gives "31", hour=45 gives "45".
- Input sampling: the inputs are read only at the start capture. Changes during a frame do not affect that frame.
- start while busy or in DONE: ignored, not queued.
- start at the same edge as reset: reset wins.
- Reset mid-frame: the frame is abandoned. After the reset edge, tx_valid=0 and the FSM is in IDLE. The next start sends a full frame from byte 0.
- tx_valid never drops without a transfer except by reset.

Optional Feature:
- Macro: TSFMT_AUTO_SEND_EN.
- Defined:
  - The block registers the sec input each cycle.
  - In IDLE, a change of sec from the previous cycle acts as start, giving one frame per second with no external start.
  - The start port still works; simultaneous start and a change launch a single frame.
  - A sec change while busy is dropped.
- Not defined: frames are sent only on start; no sec history register is built.

Test Plan:
- Basic frame: month=3, day=14, hour=9, min=5, sec=7, tx_ready=1, start pulse -> 16 consecutive valid bytes "03-14 09:05:07\r\n" (0x30 0x33 0x2D 0x31 0x34 0x20 0x30 0x39 0x3A 0x30 0x35 0x3A 0x30 0x37 0x0D 0x0A); first tx_valid 1 cycle after start; done 1 cycle after the last transfer; busy low again at DONE.
- Backpressure: hold tx_ready=0 for 5 cycles while byte 2 (0x2D) is presented, random ready on the remaining bytes -> tx_data stays 0x2D throughout the stall; no byte lost or duplicated; full frame still correct.
- Snapshot/ignore: change sec 7->8 and pulse start again during byte 4 -> frame still ends "07\r\n"; exactly one frame; no second frame afterwards.
- Saturation/limits: sec=127, min=59, hour=23, day=29, month=31 -> "31-29 23:59:99\r\n".
- Reset mid-frame: assert reset for 1 cycle while byte 6 is presented -> tx_valid=0, busy=0, tx_data=0x00 after that edge; a following start gives a complete frame from 0x30. Also run with EOL_CRLF=0 -> 15 bytes, last byte 0x0A.
- With TSFMT_AUTO_SEND_EN defined: step sec 10->11 with no start -> one frame ending "11\r\n"; step sec again while busy -> no extra frame.

Source files
------------

// File: rtl/time_stamp_tx.sv
// time_stamp_tx: snapshots the clock counter fields on request and streams
// them out as an ASCII line "MM-DD HH:MM:SS" + CR LF (or LF only) over a
// valid/ready byte interface into the UART transmitter.
// Optional build macro TSFMT_AUTO_SEND_EN: a change of the sec input while
// idle launches a frame on its own (one frame per second).
module time_stamp_tx #(
  parameter logic [7:0] DELIM_DATE = 8'h2D,
  parameter logic [7:0] DELIM_TIME = 8'h3A,
  parameter bit         EOL_CRLF   = 1'b1
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] sec,
  input  logic [6:0] min,
  input  logic [5:0] hour,
  input  logic [5:0] day,
  input  logic [4:0] month,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done
);

  localparam int         FRAME_LEN = EOL_CRLF ? 16 : 15;
  localparam logic [3:0] LAST_IDX  = 4'(FRAME_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [6:0]  sec_q, min_q;
  logic [5:0]  hour_q, day_q;
  logic [4:0]  month_q;
  logic        capture;
  logic        trig;
  logic [7:0]  frame_byte;
  logic [15:0] mo_a, dy_a, hr_a, mi_a, se_a;

  // Binary field -> two ASCII decimal digits, saturating above 99.
  function automatic logic [15:0] to_ascii(input logic [6:0] v);
    logic [6:0] s;
    logic [3:0] t, u;
    s = (v > 7'd99) ? 7'd99 : v;
    t = 4'(s / 7'd10);
    u = 4'(s % 7'd10);
    return {8'h30 + {4'h0, t}, 8'h30 + {4'h0, u}};
  endfunction

`ifdef TSFMT_AUTO_SEND_EN
  logic [6:0] sec_prev_q;

  // Previous-cycle seconds value; a difference marks a new second.
  always_ff @(posedge clk_sys) begin
    if (reset) sec_prev_q <= '0;
    else       sec_prev_q <= sec;
  end

  assign trig = start | (sec != sec_prev_q);
`else
  assign trig = start;
`endif

  assign mo_a = to_ascii({2'b00, month_q});
  assign dy_a = to_ascii({1'b0, day_q});
  assign hr_a = to_ascii({1'b0, hour_q});
  assign mi_a = to_ascii(min_q);
  assign se_a = to_ascii(sec_q);

  // Frame byte selected by the current byte index.
  always_comb begin
    frame_byte = 8'h0A;
    case (idx_q)
      4'd0:  frame_byte = mo_a[15:8];
      4'd1:  frame_byte = mo_a[7:0];
      4'd2:  frame_byte = DELIM_DATE;
      4'd3:  frame_byte = dy_a[15:8];
      4'd4:  frame_byte = dy_a[7:0];
      4'd5:  frame_byte = 8'h20;
      4'd6:  frame_byte = hr_a[15:8];
      4'd7:  frame_byte = hr_a[7:0];
      4'd8:  frame_byte = DELIM_TIME;
      4'd9:  frame_byte = mi_a[15:8];
      4'd10: frame_byte = mi_a[7:0];
      4'd11: frame_byte = DELIM_TIME;
      4'd12: frame_byte = se_a[15:8];
      4'd13: frame_byte = se_a[7:0];
      4'd14: frame_byte = EOL_CRLF ? 8'h0D : 8'h0A;
      default: frame_byte = 8'h0A;
    endcase
  end

  // FSM next state and Moore outputs; tx_data is forced to zero outside SEND.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    capture  = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trig) begin
          capture = 1'b1;
          idx_d   = 4'd0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_data  = frame_byte;
        if (tx_ready) begin
          if (idx_q == LAST_IDX) state_d = S_DONE;
          else                   idx_d   = idx_q + 4'd1;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, byte index and field snapshot; fields are only sampled at capture.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      hour_q  <= '0;
      day_q   <= '0;
      month_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (capture) begin
        sec_q   <= sec;
        min_q   <= min;
        hour_q  <= hour;
        day_q   <= day;
        month_q <= month;
      end
    end
  end

endmodule

// File: tb/tb_time_stamp_tx.sv
// Bench for time_stamp_tx: a CR LF instance and an LF-only instance share
// stimulus; transferred bytes are collected and compared against a frame
// built from a formatted string of the saturated field values.
module tb_time_stamp_tx;

  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       tx_ready = 1'b1;
  logic [6:0] sec = '0, min = '0;
  logic [5:0] hour = '0, day = '0;
  logic [4:0] month = '0;
  logic [7:0] tx_data1, tx_data2;
  logic       tx_valid1, tx_valid2, busy1, busy2, done1, done2;

  int total = 0;
  int bad = 0;
  byte unsigned q1[$], q2[$], exp1[$], exp2[$];
  int base1 = 0, base2 = 0, nd1 = 0, nd2 = 0, ndb1 = 0, ndb2 = 0;
  bit rnd = 1'b0;

  time_stamp_tx u_dut (
    .clk_sys(clk_sys), .reset(reset), .start(start),
    .sec(sec), .min(min), .hour(hour), .day(day), .month(month),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready),
    .busy(busy1), .done(done1)
  );

  time_stamp_tx #(.EOL_CRLF(1'b0)) u_dut_lf (
    .clk_sys(clk_sys), .reset(reset), .start(start),
    .sec(sec), .min(min), .hour(hour), .day(day), .month(month),
    .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready),
    .busy(busy2), .done(done2)
  );

  always #5 clk_sys = ~clk_sys;

  // Record every accepted byte and every done pulse.
  always @(posedge clk_sys) begin
    if (!reset) begin
      if (tx_valid1 && tx_ready) q1.push_back(tx_data1);
      if (tx_valid2 && tx_ready) q2.push_back(tx_data2);
      if (done1) nd1++;
      if (done2) nd2++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 99) ? 99 : v;
  endfunction

  task automatic build_exp(input int s, input int mi, input int h, input int d, input int mo);
    string str;
    str = $sformatf("%02d-%02d %02d:%02d:%02d", sat(mo), sat(d), sat(h), sat(mi), sat(s));
    exp1.delete();
    exp2.delete();
    for (int i = 0; i < str.len(); i++) begin
      exp1.push_back(str[i]);
      exp2.push_back(str[i]);
    end
    exp1.push_back(8'h0D);
    exp1.push_back(8'h0A);
    exp2.push_back(8'h0A);
  endtask

  // Drive fields and a start pulse; returns at the negedge where byte 0 shows.
  task automatic launch(input int s, input int mi, input int h, input int d, input int mo);
    @(negedge clk_sys);
    sec = 7'(s); min = 7'(mi); hour = 6'(h); day = 6'(d); month = 5'(mo);
    start = 1'b1;
    build_exp(s, mi, h, d, mo);
    @(negedge clk_sys);
    start = 1'b0;
  endtask

  task automatic wait_frame(input string tag);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!busy1 && !busy2 && !done1 && !done2) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_sys);
      if (rnd) tx_ready = 1'($urandom_range(0, 1));
    end
    chk({tag, "_timeout"}, 32'(ok), 32'd1);
    tx_ready = 1'b1;
  endtask

  task automatic sync_bases();
    base1 = q1.size(); base2 = q2.size(); ndb1 = nd1; ndb2 = nd2;
  endtask

  task automatic check_frames(input string tag);
    chk({tag, "_len16"}, 32'(q1.size() - base1), 32'(exp1.size()));
    for (int i = 0; i < exp1.size(); i++)
      if (base1 + i < q1.size())
        chk($sformatf("%s_crlf_b%0d", tag, i), 32'(q1[base1 + i]), 32'(exp1[i]));
    chk({tag, "_len15"}, 32'(q2.size() - base2), 32'(exp2.size()));
    for (int i = 0; i < exp2.size(); i++)
      if (base2 + i < q2.size())
        chk($sformatf("%s_lf_b%0d", tag, i), 32'(q2[base2 + i]), 32'(exp2[i]));
    chk({tag, "_done16"}, 32'(nd1 - ndb1), 32'd1);
    chk({tag, "_done15"}, 32'(nd2 - ndb2), 32'd1);
    sync_bases();
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk_sys);
    chk("rst_valid", 32'(tx_valid1), 0);
    chk("rst_data", 32'(tx_data1), 0);
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_done", 32'(done1), 0);
    reset = 1'b0;

    // basic frame with cycle-exact timing
    rnd = 1'b0; tx_ready = 1'b1;
    launch(7, 5, 9, 14, 3);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("basic_valid%0d", i), 32'(tx_valid1), 1);
      chk($sformatf("basic_data%0d", i), 32'(tx_data1), 32'(exp1[i]));
      @(negedge clk_sys);
    end
    chk("basic_done", 32'(done1), 1);
    chk("basic_busy_at_done", 32'(busy1), 0);
    chk("basic_valid_at_done", 32'(tx_valid1), 0);
    wait_frame("basic");
    check_frames("basic");

    // backpressure on byte 2
    rnd = 1'b0; tx_ready = 1'b1;
    launch($urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 63),
           $urandom_range(0, 63), $urandom_range(0, 31));
    @(negedge clk_sys);
    @(negedge clk_sys);
    tx_ready = 1'b0;
    chk("bp_byte2", 32'(tx_data1), 32'h2D);
    repeat (5) begin
      @(negedge clk_sys);
      chk("bp_hold", 32'(tx_data1), 32'h2D);
      chk("bp_valid", 32'(tx_valid1), 1);
    end
    rnd = 1'b1;
    wait_frame("bp");
    check_frames("bp");

    // snapshot: sec change plus start during byte 4 is ignored
    rnd = 1'b0; tx_ready = 1'b1;
    launch(7, 30, 12, 1, 6);
    repeat (4) @(negedge clk_sys);
    sec = 7'd8; start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    wait_frame("snap");
    check_frames("snap");
    repeat (30) @(negedge clk_sys);
    chk("snap_no_extra_bytes", 32'(q1.size() - base1), 0);
    chk("snap_no_extra_done", 32'(nd1 - ndb1), 0);
    chk("snap_idle", 32'(busy1), 0);

    // saturation / no range check
    rnd = 1'b1;
    launch(127, 59, 23, 29, 31);
    wait_frame("sat");
    check_frames("sat");

    // reset mid-frame at byte 6
    rnd = 1'b0; tx_ready = 1'b1;
    launch($urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 63),
           $urandom_range(0, 63), $urandom_range(0, 31));
    repeat (6) @(negedge clk_sys);
    reset = 1'b1;
    @(negedge clk_sys);
    chk("mrst_valid", 32'(tx_valid1), 0);
    chk("mrst_busy", 32'(busy1), 0);
    chk("mrst_data", 32'(tx_data1), 0);
    chk("mrst_valid_lf", 32'(tx_valid2), 0);
    sync_bases();
    reset = 1'b0; start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    chk("mrst_restart_b0", 32'(tx_data1), 32'h30 + 32'(sat(int'(month)) / 10));
    rnd = 1'b1;
    wait_frame("mrst");
    check_frames("mrst");

    // random frames with random ready
    for (int k = 0; k < 8; k++) begin
      rnd = 1'b1;
      launch($urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 63),
             $urandom_range(0, 63), $urandom_range(0, 31));
      wait_frame($sformatf("rnd%0d", k));
      check_frames($sformatf("rnd%0d", k));
    end

`ifdef TSFMT_AUTO_SEND_EN
    // auto send on a seconds step, second step while busy dropped
    rnd = 1'b0; tx_ready = 1'b1;
    @(negedge clk_sys);
    sec = 7'd10;
    @(negedge clk_sys);
    wait_frame("auto_pre");
    sync_bases();
    @(negedge clk_sys);
    sec = 7'd11;
    build_exp(11, min, hour, day, month);
    @(negedge clk_sys);
    chk("auto_started", 32'(tx_valid1), 1);
    repeat (3) @(negedge clk_sys);
    sec = 7'd12;
    wait_frame("auto");
    check_frames("auto");
    repeat (30) @(negedge clk_sys);
    chk("auto_no_extra", 32'(q1.size() - base1), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
